access_checker: RTL and testbench
=================================

Name: access_checker

Overview:
Parametrised successor to the single fixed/dynamic ID comparator in the IP wrapper. It holds an N-entry allowlist of IDs, programmed by the MicroBlaze-side register block. Each candidate ID from the generator side is checked by a sequential scan, one entry per cycle. The block emits a grant/deny response, locks out after repeated failures, and raises a sticky interrupt.

Parameters:
N_ENTRIES, 4, number of allowlist entries (>=1)
ID_W, 24, ID width in bits
MAX_FAILS, 3, consecutive denies that trigger lockout; 0 disables lockout
LOCK_CYCLES, 16, cycles spent in lockout (>=1)
CNT_W, 16, statistics counter width (optional feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  allowlist write strobe
cfg_idx  in  IDX_W  entry index; IDX_W = max(1, clog2(N_ENTRIES))
cfg_id  in  ID_W  ID value to store
cfg_en  in  1  entry enable bit to store
req_valid  in  1  candidate ID valid
req_ready  out  1  block can accept a candidate
req_id  in  ID_W  candidate ID
rsp_valid  out  1  one-cycle response pulse
rsp_granted  out  1  match found
rsp_denied  out  1  no match
rsp_idx  out  IDX_W  index of the matching entry
locked  out  1  lockout active
irq  out  1  sticky interrupt
irq_ack  in  1  clears irq

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-high (rst).
- State after reset:
  - All table entries disabled, with ID 0.
  - FSM in IDLE. Fail counter and lock timer are 0.
  - rsp_valid, rsp_granted, rsp_denied, rsp_idx, locked and irq are all 0.
  - req_ready is 1 from the first cycle after rst deasserts.
- States: IDLE, SCAN, RESP, LOCKED.
- req_ready = (state == IDLE).
- rsp_granted, rsp_denied and rsp_idx are 0 whenever rsp_valid is 0.
- IDLE: when req_valid & req_ready in cycle T, register req_id, clear the scan index, and go to SCAN.
- SCAN:
  - In cycle T+1+k, compare entry k: hit when en[k] is set and id[k] == captured ID, compared over the full ID_W bits.
  - On a hit, go to RESP as granted with rsp_idx = k.
  - At k = N_ENTRIES-1 with no hit, go to RESP as denied.
  - The lowest matching index wins.
- Latency: grant at entry k gives rsp_valid in cycle T+2+k. Deny gives rsp_valid in cycle T+1+N_ENTRIES.
- RESP: rsp_valid is high for exactly one cycle; there is no backpressure.
  - Grant clears the fail counter and returns to IDLE.
  - Deny increments the fail counter and sets irq.
  - If MAX_FAILS != 0 and the counter reaches MAX_FAILS: clear the counter, load the lock timer with LOCK_CYCLES, and go to LOCKED. Otherwise return to IDLE.
- LOCKED:
  - locked = 1 and req_ready = 0. The timer decrements each cycle.
  - The block stays exactly LOCK_CYCLES cycles in LOCKED, then returns to IDLE.
  - Requests presented during lockout are not accepted; they stay pending under valid/ready.
- irq: set on every deny response (which includes lockout entry) and cleared by irq_ack. If set and ack land in the same cycle, set wins.
- Configuration writes:
  - Accepted in any state, taking effect on the next clock edge.
  - A write to the entry being compared in the same cycle does not affect that comparison; the old value is used.
  - Writes with cfg_idx >= N_ENTRIES are ignored.
- Reset mid-operation: aborts any scan or lockout, produces no response, and clears the table.

Optional Feature:
ACCESS_CHECKER_STATS_EN:
- Defined: adds outputs grant_cnt and deny_cnt (CNT_W each).
  - Each increments on its corresponding rsp_valid pulse and saturates at all-ones.
  - Both clear on rst or on a new input stats_clr (1 bit). If stats_clr and an increment land in the same cycle, clear wins.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package access_checker_pkg:
  - FSM state enum typedef.
  - IDX_W helper function.
  - Localparams for the response codes (NONE, GRANT, DENY).
- One sub-module, access_table:
  - N_ENTRIES x (ID_W+1) register file with synchronous write and combinational indexed read.
  - Owns the cfg_idx range check and the reset clear.

Test Plan:
- Grant: program entry 2 = 0xABCDEF enabled, request 0xABCDEF accepted at cycle T -> rsp_valid at T+4 with rsp_granted=1, rsp_idx=2; irq stays 0.
- Deny and disabled entry: entry 0 holds 0x000123 with en=0, request 0x000123 -> rsp_denied=1 at T+5 (N=4), irq=1; irq_ack then clears irq; ack in the same cycle as a new deny leaves irq=1.
- Lockout: 3 consecutive denies -> locked=1 and req_ready=0 for exactly 16 cycles; a request held valid during lockout is accepted on the first IDLE cycle. A grant after 2 denies resets the count, so a further deny does not lock.
- Duplicates: entries 1 and 3 both = 0x55AA55 -> rsp_idx=1. A cfg write to entry 1 in the cycle entry 1 is compared still yields a grant from the old value.
- Reset mid-scan: assert rst one cycle into SCAN -> no rsp_valid; next cycle all outputs 0, req_ready=1; the previously programmed ID is now denied.
- With ACCESS_CHECKER_STATS_EN and CNT_W=2: 5 grants -> grant_cnt saturates at 3; stats_clr asserted with a concurrent grant -> 0.

Source files
------------

// File: rtl/access_checker_pkg.sv
// Shared types and helpers for the allowlist access checker.
package access_checker_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    RESP   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  localparam logic [1:0] RSP_NONE  = 2'd0;
  localparam logic [1:0] RSP_GRANT = 2'd1;
  localparam logic [1:0] RSP_DENY  = 2'd2;

  // Index width, never narrower than one bit even for a single-entry table.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/access_table.sv
// Allowlist register file: synchronous write with range check, combinational indexed read.
// Read data reflects the contents before any write landing on the same edge.
module access_table #(
  parameter int N_ENTRIES = 4,
  parameter int ID_W      = 24,
  parameter int IDX_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [ID_W-1:0]  cfg_id,
  input  logic             cfg_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [ID_W-1:0]  rd_id,
  output logic             rd_en
);

  logic [ID_W-1:0]      ids_q [N_ENTRIES];
  logic [N_ENTRIES-1:0] en_q;
  logic                 wr_ok;

  assign wr_ok = cfg_we && (32'(cfg_idx) < N_ENTRIES);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) ids_q[i] <= '0;
      en_q <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          ids_q[i] <= cfg_id;
          en_q[i]  <= cfg_en;
        end
      end
    end
  end

  always_comb begin
    rd_id = '0;
    rd_en = 1'b0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_id = ids_q[i];
        rd_en = en_q[i];
      end
    end
  end

endmodule

// File: rtl/access_checker.sv
// Allowlist ID checker: one entry compared per cycle, grant/deny pulse, lockout after repeated denies.
// Optional ACCESS_CHECKER_STATS_EN adds saturating grant/deny counters cleared by stats_clr.
module access_checker
  import access_checker_pkg::*;
#(
  parameter int N_ENTRIES   = 4,
  parameter int ID_W        = 24,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16,
`ifdef ACCESS_CHECKER_STATS_EN
  parameter int CNT_W       = 16,
`endif
  localparam int IDX_W      = idx_w(N_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [ID_W-1:0]  cfg_id,
  input  logic             cfg_en,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ID_W-1:0]  req_id,
  output logic             rsp_valid,
  output logic             rsp_granted,
  output logic             rsp_denied,
  output logic [IDX_W-1:0] rsp_idx,
  output logic             locked,
  output logic             irq,
`ifdef ACCESS_CHECKER_STATS_EN
  input  logic             stats_clr,
  output logic [CNT_W-1:0] grant_cnt,
  output logic [CNT_W-1:0] deny_cnt,
`endif
  input  logic             irq_ack
);

  localparam int FAIL_W = (MAX_FAILS < 2) ? 1 : $clog2(MAX_FAILS + 1);
  localparam int TMR_W  = $clog2(LOCK_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    cap_id_q, cap_id_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [FAIL_W-1:0]  fail_q, fail_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [1:0]         rsp_code_q, rsp_code_d;
  logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic               irq_q, irq_d, irq_set;
  logic [ID_W-1:0]    rd_id;
  logic               rd_en, hit;

  access_table #(.N_ENTRIES(N_ENTRIES), .ID_W(ID_W), .IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .rst     (rst),
    .cfg_we  (cfg_we),
    .cfg_idx (cfg_idx),
    .cfg_id  (cfg_id),
    .cfg_en  (cfg_en),
    .rd_idx  (scan_idx_q),
    .rd_id   (rd_id),
    .rd_en   (rd_en)
  );

  assign hit = rd_en && (rd_id == cap_id_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_id_q   <= '0;
      scan_idx_q <= '0;
      fail_q     <= '0;
      tmr_q      <= '0;
      rsp_code_q <= RSP_NONE;
      rsp_idx_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_id_q   <= cap_id_d;
      scan_idx_q <= scan_idx_d;
      fail_q     <= fail_d;
      tmr_q      <= tmr_d;
      rsp_code_q <= rsp_code_d;
      rsp_idx_q  <= rsp_idx_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cap_id_d   = cap_id_q;
    scan_idx_d = scan_idx_q;
    fail_d     = fail_q;
    tmr_d      = tmr_q;
    rsp_code_d = rsp_code_q;
    rsp_idx_d  = rsp_idx_q;
    irq_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cap_id_d   = req_id;
          scan_idx_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          rsp_code_d = RSP_GRANT;
          rsp_idx_d  = scan_idx_q;
          state_d    = RESP;
        end else if (scan_idx_q == LAST_IDX) begin
          rsp_code_d = RSP_DENY;
          rsp_idx_d  = '0;
          state_d    = RESP;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      RESP: begin
        state_d    = IDLE;
        rsp_code_d = RSP_NONE;
        if (rsp_code_q == RSP_GRANT) begin
          fail_d = '0;
        end else begin
          irq_set = 1'b1;
          if (MAX_FAILS != 0) begin
            if (int'(fail_q) + 1 >= MAX_FAILS) begin
              fail_d  = '0;
              tmr_d   = TMR_W'(LOCK_CYCLES);
              state_d = LOCKED;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end
      LOCKED: begin
        tmr_d = tmr_q - 1'b1;
        if (tmr_q == TMR_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new deny outranks an acknowledge arriving in the same cycle.
    irq_d = irq_set | (irq_q & ~irq_ack);
  end

  assign req_ready   = (state_q == IDLE);
  assign locked      = (state_q == LOCKED);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_granted = rsp_valid && (rsp_code_q == RSP_GRANT);
  assign rsp_denied  = rsp_valid && (rsp_code_q == RSP_DENY);
  assign rsp_idx     = rsp_valid ? rsp_idx_q : '0;
  assign irq         = irq_q;

`ifdef ACCESS_CHECKER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      grant_cnt <= '0;
      deny_cnt  <= '0;
    end else begin
      if (rsp_granted && (grant_cnt != '1)) grant_cnt <= grant_cnt + 1'b1;
      if (rsp_denied && (deny_cnt != '1))   deny_cnt  <= deny_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_access_checker.sv
// Directed bench for access_checker: grant/deny latency, irq, lockout, duplicates, reset mid-scan.
module tb_access_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [23:0] cfg_id;
  logic        cfg_en;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_id;
  logic        rsp_valid;
  logic        rsp_granted;
  logic        rsp_denied;
  logic [1:0]  rsp_idx;
  logic        locked;
  logic        irq;
  logic        irq_ack;
`ifdef ACCESS_CHECKER_STATS_EN
  logic        stats_clr;
  logic [1:0]  grant_cnt;
  logic [1:0]  deny_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  access_checker #(
    .N_ENTRIES   (4),
    .ID_W        (24),
    .MAX_FAILS   (3),
`ifdef ACCESS_CHECKER_STATS_EN
    .CNT_W       (2),
`endif
    .LOCK_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_id      (cfg_id),
    .cfg_en      (cfg_en),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_id      (req_id),
    .rsp_valid   (rsp_valid),
    .rsp_granted (rsp_granted),
    .rsp_denied  (rsp_denied),
    .rsp_idx     (rsp_idx),
    .locked      (locked),
    .irq         (irq),
`ifdef ACCESS_CHECKER_STATS_EN
    .stats_clr   (stats_clr),
    .grant_cnt   (grant_cnt),
    .deny_cnt    (deny_cnt),
`endif
    .irq_ack     (irq_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [23:0] id, input logic en);
    cfg_we = 1'b1; cfg_idx = idx; cfg_id = id; cfg_en = en;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic ack_irq();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  // Returns at the response cycle; lat counts cycles from the accept cycle.
  task automatic send_req(input logic [23:0] id, output int wait_c, output int lat,
                          output logic g, output logic d, output logic [1:0] ix);
    req_valid = 1'b1;
    req_id    = id;
    wait_c    = 0;
    while (!req_ready && wait_c < 64) begin
      tick();
      wait_c++;
    end
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 64) begin
      tick();
      lat++;
    end
    g  = rsp_granted;
    d  = rsp_denied;
    ix = rsp_idx;
  endtask

  initial begin
    int         w, lat, n;
    logic       g, d, seen;
    logic [1:0] ix;

    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_id = '0; cfg_en = 1'b0;
    req_valid = 1'b0; req_id = '0; irq_ack = 1'b0;
`ifdef ACCESS_CHECKER_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_ready",   req_ready,   1);
    check("rst_valid",   rsp_valid,   0);
    check("rst_granted", rsp_granted, 0);
    check("rst_denied",  rsp_denied,  0);
    check("rst_idx",     rsp_idx,     0);
    check("rst_locked",  locked,      0);
    check("rst_irq",     irq,         0);

    // Grant from entry 2 after three compares.
    cfg_write(2'd2, 24'hABCDEF, 1'b1);
    send_req(24'hABCDEF, w, lat, g, d, ix);
    check("grant_lat", lat, 4);
    check("grant_g",   g,   1);
    check("grant_d",   d,   0);
    check("grant_idx", ix,  2);
    tick();
    check("grant_pulse", rsp_valid, 0);
    check("grant_irq",   irq,       0);
    check("grant_idle",  req_ready, 1);

    // Matching ID in a disabled entry is denied.
    cfg_write(2'd0, 24'h000123, 1'b0);
    send_req(24'h000123, w, lat, g, d, ix);
    check("deny_lat", lat, 5);
    check("deny_d",   d,   1);
    check("deny_g",   g,   0);
    tick();
    check("deny_irq", irq, 1);
    ack_irq();
    check("ack_irq", irq, 0);

    // Acknowledge coinciding with a deny response leaves irq set.
    send_req(24'h000123, w, lat, g, d, ix);
    check("deny2_d", d, 1);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_vs_set_irq", irq, 1);
    check("two_fails_unlocked", locked, 0);
    ack_irq();

    // Third consecutive deny locks for 16 cycles; a held request waits.
    send_req(24'h000123, w, lat, g, d, ix);
    check("deny3_d", d, 1);
    tick();
    check("lock_locked", locked,    1);
    check("lock_ready",  req_ready, 0);
    req_valid = 1'b1;
    req_id    = 24'hABCDEF;
    n = 0;
    seen = 1'b0;
    while (locked && n < 40) begin
      if (req_ready) seen = 1'b1;
      tick();
      n++;
    end
    check("lock_len",      n,    16);
    check("lock_no_ready", seen, 0);
    send_req(24'hABCDEF, w, lat, g, d, ix);
    check("held_wait", w,   0);
    check("held_lat",  lat, 4);
    check("held_g",    g,   1);
    tick();
    ack_irq();

    // A grant between denies restarts the fail count.
    send_req(24'h000123, w, lat, g, d, ix); tick();
    send_req(24'h000123, w, lat, g, d, ix); tick();
    send_req(24'hABCDEF, w, lat, g, d, ix); tick();
    check("mid_grant_g", g, 1);
    send_req(24'h000123, w, lat, g, d, ix);
    check("post_grant_d", d, 1);
    tick();
    check("post_grant_unlocked", locked,    0);
    check("post_grant_ready",    req_ready, 1);

    // Duplicate IDs resolve to the lowest index.
    cfg_write(2'd1, 24'h55AA55, 1'b1);
    cfg_write(2'd3, 24'h55AA55, 1'b1);
    send_req(24'h55AA55, w, lat, g, d, ix);
    check("dup_lat", lat, 3);
    check("dup_g",   g,   1);
    check("dup_idx", ix,  1);
    tick();

    // Overwriting entry 1 while it is compared still grants from the old value.
    req_valid = 1'b1; req_id = 24'h55AA55;
    tick();
    req_valid = 1'b0;
    tick();
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_id = 24'h000000; cfg_en = 1'b0;
    tick();
    cfg_we = 1'b0;
    check("wr_race_valid", rsp_valid,   1);
    check("wr_race_g",     rsp_granted, 1);
    check("wr_race_idx",   rsp_idx,     1);
    tick();
    send_req(24'h55AA55, w, lat, g, d, ix);
    check("after_wr_idx", ix,  3);
    check("after_wr_lat", lat, 5);
    tick();

    // Reset one cycle into a scan aborts it and clears the table.
    send_req(24'h000777, w, lat, g, d, ix);
    tick();
    check("pre_rst_irq", irq, 1);
    req_valid = 1'b1; req_id = 24'hABCDEF;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid",  rsp_valid,   0);
    check("mrst_g",      rsp_granted, 0);
    check("mrst_ready",  req_ready,   1);
    check("mrst_locked", locked,      0);
    check("mrst_irq",    irq,         0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen = 1'b1;
      tick();
    end
    check("mrst_no_rsp", seen, 0);
    send_req(24'hABCDEF, w, lat, g, d, ix);
    check("mrst_cleared_d",   d,   1);
    check("mrst_cleared_lat", lat, 5);
    tick();

`ifdef ACCESS_CHECKER_STATS_EN
    check("stats_deny1", deny_cnt, 1);
    cfg_write(2'd2, 24'hABCDEF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send_req(24'hABCDEF, w, lat, g, d, ix);
      tick();
    end
    check("stats_grant_sat", grant_cnt, 3);
    send_req(24'hABCDEF, w, lat, g, d, ix);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr_grant", grant_cnt, 0);
    check("stats_clr_deny",  deny_cnt,  0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
